fifo_wr_arbiter: RTL

//  Round-robin arbiter sharing the write port of the async FIFO (asyn_fifo) among
//  NUM_REQ producers in the write-clock domain. Grants one producer at a time for a

---
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one async FIFO write port
// Grants one producer at a time for up to BURST words; every write is gated on fifo_full_i.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int BURST   = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       ack_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic [IDX_W-1:0]         owner_o,
  output logic                     busy_o
);

  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest offset so the requester closest after last wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (req_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_o   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          last_d  = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_i[owner_q]) begin
          state_d = IDLE;
        end else if (!fifo_full_i) begin
          ack_o[owner_q] = 1'b1;
          if (cnt_q == CNT_W'(BURST - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_wr_en_o = |ack_o;
  assign fifo_wdata_o = fifo_wr_en_o ? wdata_i[owner_q*WIDTH +: WIDTH] : '0;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q == GRANT);

endmodule
